imm_gen_pipe: RTL and testbench

//  Decode-stage immediate generator for all RV32I/RV64I formats (I,S,B,U,J,CSR-zimm) with a registered,

---
 rtl/imm_gen_pipe_pkg.sv | 20 ++
 rtl/imm_gen_pipe_if.sv | 39 +++
 rtl/imm_gen_pipe_extract.sv | 41 ++++
 rtl/imm_gen_pipe.sv | 100 ++++++++++
 tb/tb_imm_gen_pipe.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// imm_pkg: shared immediate-source encodings for the immediate generator.
// No logic; a helper classifies the reserved imm_src codes.
// Imported by imm_extract, imm_gen_pipe and imm_gen_pipe_if.
package imm_pkg;

  typedef logic [2:0] imm_src_t;

  localparam imm_src_t IMM_I    = 3'b000;
  localparam imm_src_t IMM_S    = 3'b001;
  localparam imm_src_t IMM_B    = 3'b010;
  localparam imm_src_t IMM_U    = 3'b011;
  localparam imm_src_t IMM_J    = 3'b100;
  localparam imm_src_t IMM_ZIMM = 3'b101;

  // Codes 110/111 carry no immediate format.
  function automatic logic is_reserved(input imm_src_t src);
    return (src == 3'b110) || (src == 3'b111);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: upstream (in_*) and downstream (out_*) valid/ready bundle.
// master = instruction source / result sink, slave = imm_gen_pipe.
// IMM_ILLEGAL_EN adds out_illegal; otherwise that signal does not exist.
interface imm_gen_pipe_if
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  imm_src_t         in_imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
`ifdef IMM_ILLEGAL_EN
  logic             out_illegal;
`endif

  modport master (
`ifdef IMM_ILLEGAL_EN
    input  out_illegal,
`endif
    output in_valid, in_instr, in_imm_src, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag
  );

  modport slave (
`ifdef IMM_ILLEGAL_EN
    output out_illegal,
`endif
    input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag
  );

endinterface

// File: rtl/imm_gen_pipe_extract.sv
// imm_extract: pulls the immediate field out of an RV32I/RV64I instruction word.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  imm_src_t        imm_src_i,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  logic [31:0] imm32;
  logic        unused_opcode;

  // The opcode field never contributes to an immediate.
  assign unused_opcode = ^instr_i[6:0];

  // Assemble the format's bit fields, sign-extended to 32 bits.
  always_comb begin
    imm32 = '0;
    case (imm_src_i)
      IMM_I:    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:    imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:    imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:    imm32 = {instr_i[31:12], 12'b0};
      IMM_J:    imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
      IMM_ZIMM: imm32 = {27'b0, instr_i[19:15]};
      default:  imm32 = '0;
    endcase
  end

  // Every format fits in 32 bits; zimm has bit 31 clear, so sign extension to XLEN is correct for all.
  assign imm_o     = XLEN'($signed(imm32));
  assign illegal_o = is_reserved(imm_src_i);

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator with a 2-entry (main + skid) elastic output.
// Latency: 1 cycle from in fire to out_valid; full throughput.
// Backpressure: in_ready is registered (= skid empty); flush drops both entries. Option: IMM_ILLEGAL_EN.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  entry_t          main_q, main_d, skid_q, skid_d, new_entry;
  logic            main_vld_q, main_vld_d;
  logic            skid_vld_q, skid_vld_d;
  logic            in_rdy_q, in_rdy_d;
  logic            in_fire, out_fire;
  logic [XLEN-1:0] ext_imm;
  logic            ext_illegal;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr_i   (bus.in_instr),
    .imm_src_i (bus.in_imm_src),
    .imm_o     (ext_imm),
    .illegal_o (ext_illegal)
  );

  assign new_entry = '{imm: ext_imm, tag: bus.in_tag, illegal: ext_illegal};
  assign in_fire   = bus.in_valid & in_rdy_q;
  assign out_fire  = main_vld_q & bus.out_ready;

  // Next state: drain main (refilling from skid), then place any accepted entry, flush overrides all.
  always_comb begin
    main_vld_d = main_vld_q;
    main_d     = main_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (out_fire) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = 1'b0;
      end
    end
    // in_fire never coincides with a full skid, so main is free whenever it drains.
    if (in_fire) begin
      if (!main_vld_q || out_fire) begin
        main_vld_d = 1'b1;
        main_d     = new_entry;
      end else begin
        skid_vld_d = 1'b1;
        skid_d     = new_entry;
      end
    end
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end
    in_rdy_d = !skid_vld_d;
  end

  // State registers; in_ready stays low throughout reset and rises on the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= in_rdy_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign bus.in_ready  = in_rdy_q;
  assign bus.out_valid = main_vld_q;
  assign bus.out_imm   = main_q.imm;
  assign bus.out_tag   = main_q.tag;
`ifdef IMM_ILLEGAL_EN
  assign bus.out_illegal = main_q.illegal;
`else
  logic unused_illegal;
  assign unused_illegal = main_q.illegal;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for imm_gen_pipe (XLEN=32 main DUT, XLEN=64 side DUT).
// Drivers push expected entries on each accepted input; a negedge monitor pops on each output.
// Covers formats, backpressure, flush, async reset, reserved codes and a random stretch.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
  );
  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .bus(bus64)
  );

  typedef struct {
    logic [31:0] imm;
    logic [31:0] tag;
    logic        ill;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec   = 0;
  int          n_err   = 0;
  int          n_acc   = 0;
  int          cyc     = 0;
  logic        lat_chk = 1'b0;
  logic [31:0] tag_ctr = 32'h1000_0000;
  logic        rand_on = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference immediate, built from arithmetic shifts of the field-packed word.
  function automatic logic [63:0] model_imm(input logic [31:0] ins, input logic [2:0] src);
    logic signed [31:0] r;
    case (src)
      3'd0:    r = $signed(ins) >>> 20;
      3'd1:    r = $signed({ins[31:25], ins[11:7], 20'h0}) >>> 20;
      3'd2:    r = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 20'h0}) >>> 19;
      3'd3:    r = {ins[31:12], 12'h0};
      3'd4:    r = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 12'h0}) >>> 11;
      3'd5:    r = {27'h0, ins[19:15]};
      default: r = '0;
    endcase
    return {{32{r[31]}}, r};
  endfunction

  function automatic logic [31:0] m32(input logic [31:0] ins, input logic [2:0] src);
    return 32'(model_imm(ins, src));
  endfunction

  // Present one instruction until accepted; leaves in_valid high for back-to-back use.
  task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [31:0] ximm);
    exp_t e;
    logic fired;
    bus.in_valid   = 1'b1;
    bus.in_instr   = ins;
    bus.in_imm_src = src;
    bus.in_tag     = tag_ctr;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      fired = bus.in_ready;
      if (fired && !flush && rst_n) begin
        e.imm = ximm;
        e.tag = tag_ctr;
        e.ill = (src == 3'b110) || (src == 3'b111);
        e.cyc = cyc;
        sb.push_back(e);
        n_acc++;
      end
      @(posedge clk);
      #1;
      if (fired) break;
      if (n == 39) check_eq("send_stall", {63'b0, bus.in_ready}, 64'd1);
    end
    tag_ctr++;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send64(input logic [31:0] ins, input logic [2:0] src, input logic [63:0] x);
    bus64.in_valid   = 1'b1;
    bus64.in_instr   = ins;
    bus64.in_imm_src = src;
    bus64.in_tag     = tag_ctr;
    tag_ctr++;
    @(negedge clk);
    check_eq("x64_rdy", {63'b0, bus64.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus64.in_valid = 1'b0;
    @(negedge clk);
    check_eq("x64_vld", {63'b0, bus64.out_valid}, 64'd1);
    check_eq("x64_imm", bus64.out_imm, x);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops on every output transfer and checks hold-stability while stalled.
  logic        prev_stall = 1'b0;
  logic [31:0] held_imm, held_tag;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_vld", {63'b0, bus.out_valid}, 64'd1);
        check_eq("hold_imm", {32'b0, bus.out_imm}, {32'b0, held_imm});
        check_eq("hold_tag", {32'b0, bus.out_tag}, {32'b0, held_tag});
      end
      prev_stall = bus.out_valid && !bus.out_ready && !flush;
      held_imm   = bus.out_imm;
      held_tag   = bus.out_tag;
      if (flush) begin
        sb.delete();
      end else if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", {63'b0, bus.out_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq("out_imm", {32'b0, bus.out_imm}, {32'b0, e.imm});
          check_eq("out_tag", {32'b0, bus.out_tag}, {32'b0, e.tag});
`ifdef IMM_ILLEGAL_EN
          check_eq("out_illegal", {63'b0, bus.out_illegal}, {63'b0, e.ill});
`endif
          if (lat_chk) check_eq("latency", 64'(cyc - e.cyc), 64'd1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  logic [31:0] t1_ins [5] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123452B7, 32'h001000EF};
  logic [2:0]  t1_src [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  logic [31:0] t1_exp [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800};

  initial begin
    int c0, n0;
    logic [31:0] ins;
    logic [2:0]  src;
    bus.in_valid     = 1'b0;
    bus.in_instr     = '0;
    bus.in_imm_src   = '0;
    bus.in_tag       = '0;
    bus.out_ready    = 1'b0;
    bus64.in_valid   = 1'b0;
    bus64.in_instr   = '0;
    bus64.in_imm_src = '0;
    bus64.in_tag     = '0;
    bus64.out_ready  = 1'b1;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'b0, bus.in_ready}, 64'd0);
    check_eq("rst_out_imm", {32'b0, bus.out_imm}, 64'd0);
    check_eq("rst_out_tag", {32'b0, bus.out_tag}, 64'd0);
    check_eq("rst_in_ready64", {63'b0, bus64.in_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check_eq("rdy_before_edge", {63'b0, bus.in_ready}, 64'd0);
    @(posedge clk);
    #1 check_eq("rdy_after_rst", {63'b0, bus.in_ready}, 64'd1);

    // Back-to-back formats, latency 1, one per cycle
    bus.out_ready = 1'b1;
    lat_chk = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 5; i++) send(t1_ins[i], t1_src[i], t1_exp[i]);
    check_eq("b2b_cycles", 64'(cyc - c0), 64'd5);
    idle(3);
    lat_chk = 1'b0;

    // Backpressure: three cycles of out_ready low with continuous input
    bus.out_ready = 1'b0;
    n0 = n_acc;
    send(32'h00A00513, IMM_I, m32(32'h00A00513, IMM_I));
    send(32'h80000537, IMM_U, m32(32'h80000537, IMM_U));
    fork
      begin
        @(negedge clk);
        check_eq("bp_in_ready", {63'b0, bus.in_ready}, 64'd0);
        check_eq("bp_accepted", 64'(n_acc - n0), 64'd2);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join_none
    send(32'h00112623, IMM_S, m32(32'h00112623, IMM_S));
    send(32'hFE0718E3, IMM_B, m32(32'hFE0718E3, IMM_B));
    idle(4);
    check_eq("bp_drained", 64'(sb.size()), 64'd0);

    // Flush with main and skid full, input pending
    bus.out_ready = 1'b0;
    send(32'h12300093, IMM_I, m32(32'h12300093, IMM_I));
    send(32'h45600113, IMM_I, m32(32'h45600113, IMM_I));
    bus.in_valid = 1'b1;
    bus.in_tag   = tag_ctr++;
    flush        = 1'b1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("fl_out_valid", {63'b0, bus.out_valid}, 64'd0);
    check_eq("fl_in_ready", {63'b0, bus.in_ready}, 64'd1);
    // Flush while an input actually fires: that input must vanish too
    send(32'h7FF00193, IMM_I, m32(32'h7FF00193, IMM_I));
    bus.in_valid = 1'b1;
    bus.in_tag   = tag_ctr++;
    flush        = 1'b1;
    @(negedge clk);
    check_eq("fl2_in_ready", {63'b0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("fl2_out_valid", {63'b0, bus.out_valid}, 64'd0);
    bus.out_ready = 1'b1;
    send(32'h0010006F, IMM_J, m32(32'h0010006F, IMM_J));
    idle(3);
    check_eq("fl_drained", 64'(sb.size()), 64'd0);

    // Async reset asserted between edges mid-stream
    send(32'hABCDE2B7, IMM_U, m32(32'hABCDE2B7, IMM_U));
    send(32'h00F7D073, IMM_ZIMM, m32(32'h00F7D073, IMM_ZIMM));
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_out_valid", {63'b0, bus.out_valid}, 64'd0);
    check_eq("ar_in_ready", {63'b0, bus.in_ready}, 64'd0);
    check_eq("ar_out_tag", {32'b0, bus.out_tag}, 64'd0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1 check_eq("ar_rdy_after", {63'b0, bus.in_ready}, 64'd1);
    lat_chk = 1'b1;
    send(32'hFFF00093, IMM_I, 32'hFFFFFFFF);
    send(32'h000FD073, IMM_ZIMM, 32'h0000001F);
    idle(3);
    lat_chk = 1'b0;

    // Reserved imm_src codes
    send(32'hFFFFFFFF, 3'b110, 32'h0);
    send(32'h8000A0B7, 3'b111, 32'h0);
    idle(3);

    // Random stretch with random downstream stalls
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          ins = $urandom;
          src = 3'($urandom_range(0, 7));
          send(ins, src, m32(ins, src));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        bus.in_valid = 1'b0;
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1 bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    idle(5);
    check_eq("rand_drained", 64'(sb.size()), 64'd0);

    // XLEN=64 instance
    send64(32'hFFF00093, IMM_I, 64'hFFFF_FFFF_FFFF_FFFF);
    send64(32'h800002B7, IMM_U, 64'hFFFF_FFFF_8000_0000);
    send64(32'h000FD073, IMM_ZIMM, 64'h0000_0000_0000_001F);
    send64(32'hFE20AE23, IMM_S, 64'hFFFF_FFFF_FFFF_FFFC);
    ins = 32'h8000006F;
    send64(ins, IMM_J, model_imm(ins, IMM_J));
    send64(32'h12345037, 3'b110, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
